triangle_cull: RTL and testbench

Sequential clip-stage consumer that accepts a stream of Triangle3D over a valid/ready handshake. Each triangle is registered and its nine coordinates are tested against the clip window. Out-of-bounds triangles are discarded and counted; in-bounds triangles are buffered in a small FIFO and forwarded to the rasteriser setup stage over a valid/ready handshake.

---
 rtl/triangle_cull_pkg.sv | 27 ++
 rtl/tri_fifo.sv | 60 ++++++
 rtl/triangle_cull.sv | 113 +++++++++++
 tb/tb_triangle_cull.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/triangle_cull_pkg.sv
// Shared types and clip-window limits for the triangle cull stage.
// Point3D/Triangle3D are packed so they travel as plain 144-bit buses.
package triangle_cull_pkg;

   localparam int COORD_W = 16;
   localparam int TRI_W   = 9 * COORD_W;

   localparam logic signed [COORD_W-1:0] XMIN = -16'sd1024;
   localparam logic signed [COORD_W-1:0] XMAX =  16'sd1023;
   localparam logic signed [COORD_W-1:0] YMIN = -16'sd768;
   localparam logic signed [COORD_W-1:0] YMAX =  16'sd767;
   localparam logic signed [COORD_W-1:0] ZMIN =  16'sd0;
   localparam logic signed [COORD_W-1:0] ZMAX =  16'sd32767;

   typedef struct packed {
      logic signed [COORD_W-1:0] x;
      logic signed [COORD_W-1:0] y;
      logic signed [COORD_W-1:0] z;
   } Point3D;

   typedef struct packed {
      Point3D p;
      Point3D q;
      Point3D r;
   } Triangle3D;

endpackage

// File: rtl/tri_fifo.sv
// DEPTH x W synchronous circular-buffer FIFO with flush.
// Ports: clk, rst (sync, active high), i_flush, i_push/i_data,
//        i_pop, o_data (head, zero when empty), o_full, o_empty, o_count.
module tri_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 144
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  logic [W-1:0]                 i_data,
   input  logic                         i_pop,
   output logic [W-1:0]                 o_data,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_cnt;

   logic w_push;
   logic w_pop;

   // Flush and reset dominate any transfer in the same cycle.
   assign w_push = i_push && !i_flush && !rst;
   assign w_pop  = i_pop  && !i_flush && !rst && (r_cnt != '0);

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
         else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;
   // Head is a register read; forced to zero while empty so the
   // output bus is clean after reset/flush.
   assign o_data  = o_empty ? '0 : r_mem[r_rd];

endmodule

// File: rtl/triangle_cull.sv
// Clip-stage cull: registers each triangle, drops ones outside the
// clip window, queues the rest for rasteriser setup.
// Ports: clk, rst; in_valid/in_ready/tri_in upstream;
//        out_valid/out_ready/tri_out downstream; flush; clr_count;
//        cull_count, pass_count (saturating); idle.
module triangle_cull
   import triangle_cull_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  Triangle3D        tri_in,
   output logic             out_valid,
   input  logic             out_ready,
   output Triangle3D        tri_out,
   input  logic             flush,
   input  logic             clr_count,
   output logic [CNT_W-1:0] cull_count,
   output logic [CNT_W-1:0] pass_count,
   output logic             idle
);

   localparam int CW = $clog2(DEPTH+1);

   Triangle3D        r_s1;
   logic             r_s1_valid;
   logic [CNT_W-1:0] r_cull;
   logic [CNT_W-1:0] r_pass;

   logic             w_oob;
   logic             w_full;
   logic             w_empty;
   logic [CW-1:0]    w_count;
   logic             w_pop;
   logic             w_push;
   logic             w_cull;
   logic             w_resolve;
   logic             w_ready;
   logic             w_accept;
   logic [TRI_W-1:0] w_head;

   // Signed, inclusive window test. The z upper limit equals the
   // largest 16-bit signed value, so only the lower z bound can fail.
   function automatic logic pt_oob(Point3D pt);
      return ($signed(pt.x) < XMIN) || ($signed(pt.x) > XMAX) ||
             ($signed(pt.y) < YMIN) || ($signed(pt.y) > YMAX) ||
             ($signed(pt.z) < ZMIN);
   endfunction

   assign w_oob = pt_oob(r_s1.p) || pt_oob(r_s1.q) || pt_oob(r_s1.r);

   assign w_pop  = !w_empty && out_ready && !flush;
   // A full FIFO still takes s1 when the head leaves this cycle.
   assign w_push = r_s1_valid && !w_oob && (!w_full || w_pop) && !flush;
   assign w_cull = r_s1_valid && w_oob && !flush;

   assign w_resolve = r_s1_valid && (w_oob || !w_full || w_pop);
   assign w_ready   = !rst && !flush && (!r_s1_valid || w_resolve);
   assign w_accept  = in_valid && w_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1       <= '0;
         r_s1_valid <= 1'b0;
      end else if (flush) begin
         r_s1_valid <= 1'b0;
      end else if (w_accept) begin
         r_s1       <= tri_in;
         r_s1_valid <= 1'b1;
      end else if (w_resolve) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Saturating counters; clear beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || clr_count) begin
         r_cull <= '0;
         r_pass <= '0;
      end else begin
         if (w_cull && (r_cull != '1)) r_cull <= r_cull + CNT_W'(1);
         if (w_push && (r_pass != '1)) r_pass <= r_pass + CNT_W'(1);
      end
   end

   tri_fifo #(
      .DEPTH (DEPTH),
      .W     (TRI_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (w_push),
      .i_data  (r_s1),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign in_ready   = w_ready;
   assign out_valid  = !w_empty;
   assign tri_out    = Triangle3D'(w_head);
   assign cull_count = r_cull;
   assign pass_count = r_pass;
   assign idle       = !r_s1_valid && (w_count == '0);

endmodule

// File: tb/tb_triangle_cull.sv
// Bench for triangle_cull: directed scenarios plus random traffic,
// checked every cycle against a queue-based model.
module tb_triangle_cull;
   import triangle_cull_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic      rst = 1'b1;
   logic      in_valid = 1'b0;
   logic      out_ready = 1'b0;
   logic      flush = 1'b0;
   logic      clr_count = 1'b0;
   Triangle3D tri_in = '0;

   logic        in_ready, out_valid, idle;
   Triangle3D   tri_out;
   logic [15:0] cull_count, pass_count;

   logic        s_in_ready, s_out_valid, s_idle;
   Triangle3D   s_tri_out;
   logic [1:0]  s_cull, s_pass;

   triangle_cull #(.DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .tri_in(tri_in), .out_valid(out_valid), .out_ready(out_ready),
      .tri_out(tri_out), .flush(flush), .clr_count(clr_count),
      .cull_count(cull_count), .pass_count(pass_count), .idle(idle)
   );

   triangle_cull #(.DEPTH(DEPTH), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .tri_in(tri_in), .out_valid(s_out_valid), .out_ready(out_ready),
      .tri_out(s_tri_out), .flush(flush), .clr_count(clr_count),
      .cull_count(s_cull), .pass_count(s_pass), .idle(s_idle)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
      end
   endtask

   task automatic chkt(string n, logic [143:0] got, logic [143:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit        m_init = 0;
   bit        m_s1v = 0;
   Triangle3D m_s1 = '0;
   Triangle3D m_q[$];
   int        m_cull = 0;
   int        m_pass = 0;

   function automatic bit p_oob(Point3D p);
      int x, y, z;
      x = int'($signed(p.x));
      y = int'($signed(p.y));
      z = int'($signed(p.z));
      // z above 32767 cannot be represented in 16 bits
      return x < -1024 || x > 1023 || y < -768 || y > 767 || z < 0;
   endfunction

   function automatic bit t_oob(Triangle3D t);
      return p_oob(t.p) || p_oob(t.q) || p_oob(t.r);
   endfunction

   function automatic bit exp_ready();
      if (rst || flush) return 1'b0;
      if (!m_s1v) return 1'b1;
      return t_oob(m_s1) || (m_q.size() < DEPTH) || out_ready;
   endfunction

   function automatic int sat(int v, int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_edge();
      bit rdy, pop, push, res;
      rdy = exp_ready();
      if (rst) begin
         m_s1v = 0; m_q.delete(); m_cull = 0; m_pass = 0; m_init = 1;
         return;
      end
      if (flush) begin
         m_s1v = 0; m_q.delete();
         if (clr_count) begin m_cull = 0; m_pass = 0; end
         return;
      end
      pop = (m_q.size() > 0) && out_ready;
      push = 0; res = 0;
      if (m_s1v) begin
         if (t_oob(m_s1)) begin
            m_cull++; res = 1;
         end else if (m_q.size() < DEPTH || pop) begin
            m_pass++; push = 1; res = 1;
         end
      end
      if (clr_count) begin m_cull = 0; m_pass = 0; end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(m_s1);
      if (in_valid && rdy) begin
         m_s1 = tri_in; m_s1v = 1;
      end else if (res) begin
         m_s1v = 0;
      end
   endtask

   always @(negedge clk) begin
      if (m_init) begin
         Triangle3D eh;
         eh = (m_q.size() != 0) ? m_q[0] : '0;
         chk("in_ready", 32'(in_ready), 32'(exp_ready()));
         chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
         chkt("tri_out", tri_out, eh);
         chk("cull_count", 32'(cull_count), 32'(sat(m_cull, 16)));
         chk("pass_count", 32'(pass_count), 32'(sat(m_pass, 16)));
         chk("cull_sat", 32'(s_cull), 32'(sat(m_cull, 2)));
         chk("pass_sat", 32'(s_pass), 32'(sat(m_pass, 2)));
         chk("idle", 32'(idle), 32'(!m_s1v && m_q.size() == 0));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(bit iv, Triangle3D t, bit ordy, bit fl, bit clr);
      in_valid = iv; tri_in = t; out_ready = ordy;
      flush = fl; clr_count = clr;
   endtask

   function automatic Triangle3D mk(int a, int b, int c);
      Triangle3D t;
      t = '0;
      t.p.x = 16'(a); t.q.y = 16'(b); t.r.z = 16'(c);
      return t;
   endfunction

   function automatic logic [15:0] rc(int lo, int hi, bit inb);
      int r, v;
      r = int'($urandom_range(0, 9));
      if (inb || r > 3) v = lo + int'($urandom_range(0, $unsigned(hi - lo)));
      else if (r == 0) v = lo - 1;
      else if (r == 1) v = lo;
      else if (r == 2) v = hi;
      else v = hi + 1;
      return 16'(v);
   endfunction

   function automatic Point3D rpt(bit inb);
      Point3D p;
      p.x = rc(-1024, 1023, inb);
      p.y = rc(-768, 767, inb);
      p.z = rc(0, 32767, inb);
      return p;
   endfunction

   function automatic Triangle3D rtri();
      Triangle3D t;
      bit inb;
      inb = ($urandom_range(0, 9) < 7);
      t.p = rpt(inb); t.q = rpt(inb); t.r = rpt(inb);
      return t;
   endfunction

   task automatic wait_idle(string n);
      for (int i = 0; i < 40 && !idle; i++) tick();
      chk(n, 32'(idle), 32'd1);
   endtask

   Triangle3D tv[10];
   Triangle3D base;
   int sc, sp;

   initial begin
      // reset
      drive(0, '0, 1, 0, 0);
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chkt("rst_tri_out", tri_out, '0);
      chk("rst_idle", 32'(idle), 32'd1);

      // in-bounds stream, latency and order
      base = '0;
      base.q.x = 16'sd1023; base.q.y = 16'sd767; base.q.z = 16'sd32767;
      base.r.x = -16'sd1024; base.r.y = -16'sd768;
      for (int i = 0; i < 3; i++) begin
         tv[i] = base; tv[i].p.z = 16'(i);
      end
      drive(1, tv[0], 1, 0, 0); tick();
      chk("lat_n1", 32'(out_valid), 32'd0);
      drive(1, tv[1], 1, 0, 0); tick();
      chk("lat_n2", 32'(out_valid), 32'd1);
      chkt("ord0", tri_out, tv[0]);
      drive(1, tv[2], 1, 0, 0); tick();
      chkt("ord1", tri_out, tv[1]);
      drive(0, '0, 1, 0, 0); tick();
      chkt("ord2", tri_out, tv[2]);
      tick();
      chk("ib_pass", 32'(pass_count), 32'd3);
      chk("ib_cull", 32'(cull_count), 32'd0);

      // boundary just outside the window
      drive(1, mk(1024, 0, 0), 1, 0, 0); tick();
      drive(1, mk(0, -769, 0), 1, 0, 0); tick();
      drive(1, mk(0, 0, -1), 1, 0, 0); tick();
      drive(0, '0, 1, 0, 0); tick();
      chk("bnd_cull", 32'(cull_count), 32'd3);
      chk("bnd_pass", 32'(pass_count), 32'd3);
      chk("bnd_ov", 32'(out_valid), 32'd0);

      // backpressure: fill FIFO, hold s1, then drain
      drive(0, '0, 1, 0, 1); tick();
      for (int i = 0; i < 6; i++) tv[i] = mk(i + 10, -i, i * 7);
      for (int i = 0; i < 5; i++) begin
         drive(1, tv[i], 0, 0, 0); tick();
      end
      drive(1, tv[5], 0, 0, 0); #1;
      chk("bp_ready_lo", 32'(in_ready), 32'd0);
      tick();
      chkt("bp_stable0", tri_out, tv[0]);
      chk("bp_ready_lo2", 32'(in_ready), 32'd0);
      tick();
      chkt("bp_stable1", tri_out, tv[0]);
      drive(1, tv[5], 1, 0, 0); #1;
      chk("bp_ready_hi", 32'(in_ready), 32'd1);
      tick();
      drive(0, '0, 1, 0, 0);
      for (int i = 1; i < 6; i++) begin
         chkt("bp_drain", tri_out, tv[i]);
         tick();
      end
      tick();
      chk("bp_pass", 32'(pass_count), 32'd6);

      // full FIFO with simultaneous push/pop keeps 1/cycle
      for (int i = 0; i < 10; i++) tv[i] = mk(-i, i + 3, 100 + i);
      for (int i = 0; i < 5; i++) begin
         drive(1, tv[i], 0, 0, 0); tick();
      end
      for (int i = 5; i < 10; i++) begin
         drive(1, tv[i], 1, 0, 0); #1;
         chk("pp_ready", 32'(in_ready), 32'd1);
         tick();
         chkt("pp_head", tri_out, tv[i - 4]);
      end
      drive(0, '0, 1, 0, 0);
      wait_idle("pp_drain");

      // flush with 3 in FIFO and 1 in s1
      for (int i = 0; i < 5; i++) tv[i] = mk(i, i, i);
      for (int i = 0; i < 4; i++) begin
         drive(1, tv[i], 0, 0, 0); tick();
      end
      sc = int'(cull_count); sp = int'(pass_count);
      drive(1, tv[4], 0, 1, 0); #1;
      chk("fl_ready", 32'(in_ready), 32'd0);
      tick();
      chk("fl_ov", 32'(out_valid), 32'd0);
      chk("fl_idle", 32'(idle), 32'd1);
      chk("fl_cull", 32'(cull_count), 32'(sc));
      chk("fl_pass", 32'(pass_count), 32'(sp));
      drive(1, mk(7, 7, 7), 1, 0, 0); #1;
      chk("fl_accept", 32'(in_ready), 32'd1);
      tick();
      drive(0, '0, 1, 0, 0); tick();
      chk("fl_emerge", 32'(out_valid), 32'd1);
      chkt("fl_tri", tri_out, mk(7, 7, 7));
      tick();

      // saturation (2-bit instance) and clear-wins
      drive(0, '0, 1, 0, 1); tick();
      for (int i = 0; i < 5; i++) begin
         drive(1, mk(2000, 0, 0), 1, 0, 0); tick();
      end
      drive(0, '0, 1, 0, 0); tick();
      chk("sat_cull", 32'(s_cull), 32'd3);
      chk("sat_cull16", 32'(cull_count), 32'd5);
      tick(); tick();
      chk("sat_hold", 32'(s_cull), 32'd3);
      drive(1, mk(0, 900, 0), 1, 0, 0); tick();
      drive(0, '0, 1, 0, 1); tick();
      chk("clr_wins_s", 32'(s_cull), 32'd0);
      chk("clr_wins", 32'(cull_count), 32'd0);
      drive(0, '0, 1, 0, 0); tick();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         drive($urandom_range(0, 3) != 0, rtri(),
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 59) == 0,
               $urandom_range(0, 79) == 0);
         tick();
      end
      rst = 1'b0;
      drive(0, '0, 1, 0, 0);
      wait_idle("final_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
